native_bus_dma: RTL and testbench
=================================

# native_bus_dma

Word-copy / word-fill DMA engine that acts as an initiator on the PicoRV32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata). It plugs into a spare port of the shared-memory arbiter in place of a CPU core. It moves blocks of 32-bit words between memory regions, or fills a region with a constant, without CPU involvement. A watchdog aborts transfers the responder never acknowledges, such as unmapped addresses or reads of write-only IO.

## Interface
- TIMEOUT, 255: cycles a request may wait for mem_ready before abort; legal range 1..65535.
- LEN_W, 16: width of word count.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- cfg_start  in  1  start pulse; sampled only in IDLE.
- cfg_mode  in  1  0 = copy, 1 = fill.
- cfg_src  in  32  source byte address; bits [1:0] ignored.
- cfg_dst  in  32  destination byte address; bits [1:0] ignored.
- cfg_len  in  LEN_W  number of words to transfer.
- cfg_fill  in  32  fill value (mode 1).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of job, on success or abort.
- error  out  1  sticky abort flag; cleared by the next accepted start.
- words_done  out  LEN_W  words fully written in current/last job.
- mem_valid  out  1  request valid.
- mem_ready  in  1  responder acknowledge.
- mem_addr  out  32  word-aligned request address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'b1111 on writes, 4'b0000 on reads.
- mem_rdata  in  32  read data, valid in the mem_ready cycle.

## Operation
- States: IDLE, READ, WRITE, GAP, FINISH.
- IDLE: cfg_start=1 latches src/dst (low 2 bits forced 0), len, mode and fill. It clears error and words_done.
  - len=0: go to FINISH, no bus activity.
  - mode 0: go to READ.
  - mode 1: go to WRITE with mem_wdata=fill.
- cfg_* inputs are ignored while busy.
- READ: mem_valid=1, mem_addr=src, mem_wstrb=0.
  - On mem_valid&&mem_ready: capture mem_rdata into mem_wdata, src += 4, go to GAP with next=WRITE.
- WRITE: mem_valid=1, mem_addr=dst, mem_wstrb=4'hF, mem_wdata held.
  - On handshake: dst += 4, words_done += 1.
  - If words_done+1 == len: go to FINISH.
  - Otherwise go to GAP with next=READ (copy) or WRITE (fill).
- GAP: mem_valid=0 for exactly one cycle, then enter the next state. This guarantees the responder's "!mem_ready" re-arm.
- FINISH: done=1 for one cycle, mem_valid=0, then IDLE.
- Request stability: mem_addr, mem_wdata and mem_wstrb are constant from mem_valid rise until the handshake cycle inclusive. mem_valid never drops without a handshake except on abort or reset.
- Watchdog: a counter clears on entry to READ/WRITE and increments each cycle with mem_valid=1 and mem_ready=0.
  - When it reaches TIMEOUT: mem_valid drops next cycle, error=1, go to FINISH.
  - words_done keeps the count of completed words.
- Address arithmetic is modulo 2^32: 0xFFFF_FFFC + 4 wraps to 0x0000_0000 with no error.
- mem_ready while mem_valid=0 is ignored.
- Reset (any state, including mid-handshake): next edge gives IDLE and every output 0. This covers mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, done, error and words_done.

## Timing
- All outputs are registered or decoded directly from the state register; there are no combinational paths from mem_ready or mem_rdata to outputs.
- cfg_start sampled at edge T: busy=1 and mem_valid=1 from cycle T+1.
- Handshake at edge H: mem_valid=0 during cycle H+1 (GAP), next request valid at H+2.
- With a responder acking one cycle after valid, each transfer takes 3 cycles. A copy word costs 6 cycles and a fill word 3 cycles.
- done is high in the cycle after the final write handshake. busy is high through that cycle and low the cycle after.
- len=0: done is high at T+1, busy falls at T+2.
- Abort: valid held for TIMEOUT cycles after rise, FINISH on the following cycle.

## Test plan
- Copy, len=3, src=0x100, dst=0x200, memory[0x40..0x42]={A,B,C} with 1-cycle-ack model:
  - bus sequence is R100, W200=A, R104, W204=B, R108, W208=C;
  - done fires 18 cycles after start; words_done=3; error=0.
- Fill, len=4, dst=0x0, fill=0xDEADBEEF:
  - four writes to 0x0, 0x4, 0x8, 0xC, each with wstrb=F;
  - valid low for one cycle between writes; done at 12 cycles.
- Wait-state responder acks after 0/3/7 random cycles: mem_addr/wdata/wstrb are stable across every stall, and data matches.
- Timeout with TIMEOUT=8, read from 0x1000_0000 that is never acked:
  - valid high exactly 8 cycles, then drops;
  - error=1, done pulse, words_done=0;
  - the next start clears error.
- Wrap and len=0:
  - dst=0xFFFF_FFFC fill len=2 writes 0xFFFF_FFFC then 0x0;
  - len=0 start gives done at T+1 with no mem_valid;
  - cfg_start pulsed while busy is ignored.
- Reset mid-write (resetn low while mem_valid=1): next cycle all outputs 0 and state IDLE; a fresh job then completes normally.

Source files
------------

// File: rtl/native_bus_dma_if.sv
// native_bus_dma_if
//   PicoRV32 native memory bus, grouped as one bundle so that an initiator
//   and a responder can be connected with a single port.
//
//   Signals:
//     mem_valid  initiator -> responder  request valid
//     mem_ready  responder -> initiator  acknowledge; completes the request
//     mem_addr   initiator -> responder  word-aligned byte address
//     mem_wdata  initiator -> responder  write data
//     mem_wstrb  initiator -> responder  byte strobes, 4'b0000 means read
//     mem_rdata  responder -> initiator  read data, valid with mem_ready
//
//   Modports:
//     master  the initiator side (the DMA engine)
//     slave   the responder side (memory, arbiter port or test model)
interface native_bus_dma_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/native_bus_dma.sv
// native_bus_dma
//   Word-copy / word-fill DMA engine. It is an initiator on the PicoRV32
//   native memory bus and copies blocks of 32-bit words, or fills a region
//   with a constant, without CPU help. A watchdog gives up on any request
//   the responder never acknowledges and flags the job as aborted.
//
//   Parameters:
//     TIMEOUT  cycles a request may wait for mem_ready (1..65535)
//     LEN_W    width of the word count
//
//   Ports:
//     clk         clock
//     resetn      synchronous, active-low reset
//     cfg_start   start pulse, only looked at while idle
//     cfg_mode    0 = copy, 1 = fill
//     cfg_src     source byte address (bits [1:0] ignored)
//     cfg_dst     destination byte address (bits [1:0] ignored)
//     cfg_len     number of words to move
//     cfg_fill    fill value for mode 1
//     busy        high whenever a job is in progress
//     done        one-cycle pulse at the end of every job
//     error       sticky abort flag, cleared by the next accepted start
//     words_done  words written by the current / last job
//     mem         native bus, master side
module native_bus_dma #(
  parameter int TIMEOUT = 255,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_start,
  input  logic             cfg_mode,
  input  logic [31:0]      cfg_src,
  input  logic [31:0]      cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [31:0]      cfg_fill,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_done,
  native_bus_dma_if.master mem
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    GAP,
    FINISH
  } state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  localparam logic [31:0] WORD_MASK   = 32'hFFFF_FFFC;

  state_t           state;
  state_t           next_state;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [LEN_W-1:0] len;
  logic             mode;
  logic [15:0]      wd_cnt;

  logic             handshake;
  logic             last_word;
  logic [15:0]      wd_next;

  // mem_ready is only meaningful while we are actually requesting.
  assign handshake = mem.mem_valid && mem.mem_ready;
  assign last_word = (words_done + LEN_W'(1)) == len;
  assign wd_next   = wd_cnt + 16'd1;

  // Single sequential FSM. Every output, including the bus request, is a
  // register so nothing combinational leaks from mem_ready/mem_rdata to the
  // outputs. done defaults low so it can only ever be a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      next_state    <= IDLE;
      src           <= '0;
      dst           <= '0;
      len           <= '0;
      mode          <= 1'b0;
      wd_cnt        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_done    <= '0;
      mem.mem_valid <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_wstrb <= '0;
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (cfg_start) begin
            src        <= cfg_src & WORD_MASK;
            dst        <= cfg_dst & WORD_MASK;
            len        <= cfg_len;
            mode       <= cfg_mode;
            error      <= 1'b0;
            words_done <= '0;
            wd_cnt     <= '0;
            busy       <= 1'b1;
            if (cfg_len == '0) begin
              // Empty job: report completion without touching the bus.
              state <= FINISH;
              done  <= 1'b1;
            end else if (!cfg_mode) begin
              state         <= READ;
              mem.mem_valid <= 1'b1;
              mem.mem_addr  <= cfg_src & WORD_MASK;
              mem.mem_wstrb <= 4'h0;
            end else begin
              // The fill value lives in mem_wdata for the whole job; fill
              // writes never overwrite it.
              state         <= WRITE;
              mem.mem_valid <= 1'b1;
              mem.mem_addr  <= cfg_dst & WORD_MASK;
              mem.mem_wstrb <= 4'hF;
              mem.mem_wdata <= cfg_fill;
            end
          end
        end

        READ: begin
          if (handshake) begin
            mem.mem_valid <= 1'b0;
            mem.mem_wdata <= mem.mem_rdata;
            src           <= src + 32'd4;
            state         <= GAP;
            next_state    <= WRITE;
          end else if (wd_next == TIMEOUT_CNT) begin
            mem.mem_valid <= 1'b0;
            error         <= 1'b1;
            done          <= 1'b1;
            state         <= FINISH;
          end else begin
            wd_cnt <= wd_next;
          end
        end

        WRITE: begin
          if (handshake) begin
            mem.mem_valid <= 1'b0;
            dst           <= dst + 32'd4;
            words_done    <= words_done + LEN_W'(1);
            if (last_word) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state      <= GAP;
              next_state <= mode ? WRITE : READ;
            end
          end else if (wd_next == TIMEOUT_CNT) begin
            mem.mem_valid <= 1'b0;
            error         <= 1'b1;
            done          <= 1'b1;
            state         <= FINISH;
          end else begin
            wd_cnt <= wd_next;
          end
        end

        // One idle bus cycle between requests so the responder can see
        // mem_valid low and re-arm before the next request.
        GAP: begin
          state         <= next_state;
          wd_cnt        <= '0;
          mem.mem_valid <= 1'b1;
          if (next_state == READ) begin
            mem.mem_addr  <= src;
            mem.mem_wstrb <= 4'h0;
          end else begin
            mem.mem_addr  <= dst;
            mem.mem_wstrb <= 4'hF;
          end
        end

        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          mem.mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_native_bus_dma.sv
// tb_native_bus_dma
//   Self-checking bench for native_bus_dma. A reference model computes, per
//   job, the list of bus transfers and the final words_done/error from the
//   job description alone; those go into queues. A responder process plays
//   memory with fixed or random wait states, and a monitor pops and compares
//   each transfer and each done pulse, plus request stability, the one-cycle
//   gap and the watchdog length.
//
//   Ports: none (top-level bench).
module tb_native_bus_dma;

  localparam int TIMEOUT_P = 8;
  localparam int LEN_W     = 16;

  logic        clk;
  logic        resetn;
  logic        cfg_start;
  logic        cfg_mode;
  logic [31:0] cfg_src;
  logic [31:0] cfg_dst;
  logic [15:0] cfg_len;
  logic [31:0] cfg_fill;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_done;

  native_bus_dma_if bus ();

  native_bus_dma #(
    .TIMEOUT(TIMEOUT_P),
    .LEN_W  (LEN_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cfg_start (cfg_start),
    .cfg_mode  (cfg_mode),
    .cfg_src   (cfg_src),
    .cfg_dst   (cfg_dst),
    .cfg_len   (cfg_len),
    .cfg_fill  (cfg_fill),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .words_done(words_done),
    .mem       (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
  } txn_t;

  typedef struct packed {
    logic [15:0] words;
    logic        err;
  } job_t;

  txn_t        exp_q[$];
  job_t        job_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] bus_mem[logic [31:0]];

  int tests = 0;
  int fails = 0;

  // Responder behaviour: delay_mode 0 = ack one cycle after valid,
  // 1 = random 0/3/7 wait cycles. ack_budget < 0 means unlimited acks.
  int delay_mode = 0;
  int ack_budget = -1;

  int   dn;
  logic fe;
  logic fv;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] bench did not complete");
  end

  function automatic logic [31:0] def_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[17:2]};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : def_word(a);
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : def_word(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},       32'(busy),          32'd0);
    checkOutput({tag, "_done"},       32'(done),          32'd0);
    checkOutput({tag, "_error"},      32'(error),         32'd0);
    checkOutput({tag, "_words_done"}, 32'(words_done),    32'd0);
    checkOutput({tag, "_mem_valid"},  32'(bus.mem_valid), 32'd0);
    checkOutput({tag, "_mem_addr"},   bus.mem_addr,       32'd0);
    checkOutput({tag, "_mem_wdata"},  bus.mem_wdata,      32'd0);
    checkOutput({tag, "_mem_wstrb"},  32'(bus.mem_wstrb), 32'd0);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    ref_mem[a] = v;
    bus_mem[a] = v;
  endtask

  // Reference model: walks the job word by word, as a sequence of bus
  // transfers, stopping where the responder will stop acknowledging.
  task automatic model_job(input logic mode, input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] len, input logic [31:0] fill, input int acks_ok);
    logic [31:0] s;
    logic [31:0] d;
    logic [31:0] v;
    int          acks;
    job_t        j;
    s       = src & 32'hFFFF_FFFC;
    d       = dst & 32'hFFFF_FFFC;
    acks    = acks_ok;
    j.words = 16'd0;
    j.err   = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      if (!mode) begin
        if (acks == 0) begin
          j.err = 1'b1;
          break;
        end
        v = ref_rd(s);
        exp_q.push_back('{addr: s, write: 1'b0, data: v});
        if (acks > 0) acks--;
        s = s + 32'd4;
      end else begin
        v = fill;
      end
      if (acks == 0) begin
        j.err = 1'b1;
        break;
      end
      exp_q.push_back('{addr: d, write: 1'b1, data: v});
      ref_mem[d] = v;
      if (acks > 0) acks--;
      d       = d + 32'd4;
      j.words = j.words + 16'd1;
    end
    job_q.push_back(j);
  endtask

  // Runs one job: model first, then the start pulse, then a bounded wait
  // for done. done_n counts cycles from the sampling edge (1 = T+1).
  task automatic applyStimulus(input logic mode, input logic [31:0] src, input logic [31:0] dst,
                               input logic [15:0] len, input logic [31:0] fill, input int acks,
                               input logic stray, output int done_n, output logic first_err,
                               output logic first_valid);
    model_job(mode, src, dst, len, fill, acks);
    ack_budget = acks;
    @(negedge clk);
    cfg_mode  = mode;
    cfg_src   = src;
    cfg_dst   = dst;
    cfg_len   = len;
    cfg_fill  = fill;
    cfg_start = 1'b1;
    done_n      = -1;
    first_err   = 1'b0;
    first_valid = 1'b0;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      cfg_start = 1'b0;
      if (n == 1) begin
        first_err   = error;
        first_valid = bus.mem_valid;
      end
      if (stray && n == 2) begin
        cfg_mode  = ~mode;
        cfg_src   = $urandom;
        cfg_dst   = $urandom;
        cfg_len   = 16'd5;
        cfg_fill  = $urandom;
        cfg_start = busy;
      end
      if (done) begin
        done_n = n;
        break;
      end
    end
    cfg_start = 1'b0;
    if (done_n < 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL job_timeout: got no done within 3000 cycles, expected done");
    end else begin
      @(negedge clk);
      checkOutput("busy_after_done", 32'(busy), 32'd0);
    end
  endtask

  // Responder: decides mem_ready for the coming edge at each falling edge.
  initial begin : responder
    int          waited;
    int          cur_delay;
    logic [31:0] a;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;
    waited        = 0;
    cur_delay     = 1;
    forever begin
      @(negedge clk);
      if (!bus.mem_valid || !resetn) begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
        waited        = 0;
        if (delay_mode == 0) cur_delay = 1;
        else begin
          case ($urandom_range(0, 2))
            0:       cur_delay = 0;
            1:       cur_delay = 3;
            default: cur_delay = 7;
          endcase
        end
      end else if (ack_budget != 0 && waited == cur_delay) begin
        bus.mem_ready = 1'b1;
        a = bus.mem_addr;
        if (bus.mem_wstrb == 4'h0) begin
          bus.mem_rdata = bus_rd(a);
        end else begin
          bus_mem[a]    = bus.mem_wdata;
          bus.mem_rdata = $urandom;
        end
        if (ack_budget > 0) ack_budget--;
        waited++;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
        waited++;
      end
    end
  end

  // Monitor: samples each cycle just after the falling edge.
  initial begin : monitor
    logic        prev_valid;
    logic        prev_hs;
    logic        prev_done;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;
    logic [3:0]  prev_wstrb;
    logic        hs;
    int          run;
    txn_t        t;
    job_t        j;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    prev_done  = 1'b0;
    prev_addr  = '0;
    prev_wdata = '0;
    prev_wstrb = '0;
    run        = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!resetn) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        prev_done  = 1'b0;
        run        = 0;
      end else begin
        hs = bus.mem_valid && bus.mem_ready;
        if (prev_hs) checkOutput("gap_after_handshake", 32'(bus.mem_valid), 32'd0);
        if (prev_valid && !prev_hs) begin
          if (bus.mem_valid) begin
            checkOutput("stall_addr_stable",  bus.mem_addr,       prev_addr);
            checkOutput("stall_wdata_stable", bus.mem_wdata,      prev_wdata);
            checkOutput("stall_wstrb_stable", 32'(bus.mem_wstrb), 32'(prev_wstrb));
          end else begin
            checkOutput("abort_valid_cycles", 32'(run), 32'(TIMEOUT_P));
          end
        end
        if (prev_done) checkOutput("done_single_cycle", 32'(done), 32'd0);
        if (hs) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_txn: got addr %h wstrb %h, expected no transfer",
                     bus.mem_addr, bus.mem_wstrb);
          end else begin
            t = exp_q.pop_front();
            checkOutput("txn_addr",  bus.mem_addr,       t.addr);
            checkOutput("txn_wstrb", 32'(bus.mem_wstrb), t.write ? 32'hF : 32'h0);
            if (t.write) checkOutput("txn_wdata", bus.mem_wdata, t.data);
          end
        end
        if (done) begin
          if (job_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_done: got done with words_done %0d, expected no job",
                     words_done);
          end else begin
            j = job_q.pop_front();
            checkOutput("job_words_done", 32'(words_done), 32'(j.words));
            checkOutput("job_error",      32'(error),      32'(j.err));
            checkOutput("busy_with_done", 32'(busy),       32'd1);
          end
        end
        if (bus.mem_valid) run = (prev_valid && !prev_hs) ? run + 1 : 1;
        else run = 0;
        prev_valid = bus.mem_valid;
        prev_hs    = hs;
        prev_done  = done;
        prev_addr  = bus.mem_addr;
        prev_wdata = bus.mem_wdata;
        prev_wstrb = bus.mem_wstrb;
      end
    end
  end

  initial begin : stimulus
    logic        rmode;
    logic [31:0] rsrc;
    logic [31:0] rdst;
    logic [15:0] rlen;
    resetn    = 1'b0;
    cfg_start = 1'b0;
    cfg_mode  = 1'b0;
    cfg_src   = '0;
    cfg_dst   = '0;
    cfg_len   = '0;
    cfg_fill  = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    resetn = 1'b1;

    // Copy of three preloaded words with a one-cycle-ack responder.
    delay_mode = 0;
    preload(32'h100, 32'h1111_AAAA);
    preload(32'h104, 32'h2222_BBBB);
    preload(32'h108, 32'h3333_CCCC);
    applyStimulus(1'b0, 32'h100, 32'h200, 16'd3, 32'h0, -1, 1'b0, dn, fe, fv);
    checkOutput("copy_done_cycles", 32'(dn), 32'd18);
    checkOutput("copy_first_valid", 32'(fv), 32'd1);
    checkOutput("copy_words_hold",  32'(words_done), 32'd3);

    // Fill of four words.
    applyStimulus(1'b1, 32'h0, 32'h0, 16'd4, 32'hDEAD_BEEF, -1, 1'b0, dn, fe, fv);
    checkOutput("fill_done_cycles", 32'(dn), 32'd12);

    // Read that is never acknowledged: watchdog abort.
    applyStimulus(1'b0, 32'h1000_0000, 32'h300, 16'd2, 32'h0, 0, 1'b0, dn, fe, fv);
    checkOutput("timeout_done_cycles", 32'(dn), 32'd9);
    checkOutput("timeout_error_sticky", 32'(error), 32'd1);
    checkOutput("timeout_words_done", 32'(words_done), 32'd0);

    // Fill that stalls on its third write; the next start clears error.
    applyStimulus(1'b1, 32'h0, 32'h700, 16'd3, 32'hCAFE_F00D, 2, 1'b0, dn, fe, fv);
    checkOutput("restart_clears_error", 32'(fe), 32'd0);
    checkOutput("partial_done_cycles", 32'(dn), 32'd15);

    // Destination wraps from the top of the address space to zero.
    applyStimulus(1'b1, 32'h0, 32'hFFFF_FFFC, 16'd2, 32'h1234_5678, -1, 1'b0, dn, fe, fv);
    checkOutput("wrap_error_clear", 32'(fe), 32'd0);
    checkOutput("wrap_done_cycles", 32'(dn), 32'd6);

    // Empty job: done right away, no request.
    applyStimulus(1'b0, 32'h100, 32'h200, 16'd0, 32'h0, -1, 1'b0, dn, fe, fv);
    checkOutput("len0_done_cycles", 32'(dn), 32'd1);
    checkOutput("len0_no_valid",    32'(fv), 32'd0);

    // Start pulsed while busy with a different job description.
    applyStimulus(1'b1, 32'h0, 32'h500, 16'd2, 32'h0BAD_0BAD, -1, 1'b1, dn, fe, fv);
    checkOutput("stray_done_cycles", 32'(dn), 32'd6);

    // Reset while a write is outstanding.
    ack_budget = 0;
    @(negedge clk);
    cfg_mode  = 1'b1;
    cfg_dst   = 32'h400;
    cfg_len   = 16'd3;
    cfg_fill  = 32'h5555_AAAA;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    @(negedge clk);
    checkOutput("valid_before_reset", 32'(bus.mem_valid), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    checkAllZero("mid_reset");
    resetn = 1'b1;
    applyStimulus(1'b0, 32'h100, 32'h600, 16'd2, 32'h0, -1, 1'b0, dn, fe, fv);
    checkOutput("post_reset_done_cycles", 32'(dn), 32'd12);

    // Random jobs against a responder with 0/3/7 wait states.
    delay_mode = 1;
    for (int k = 0; k < 30; k++) begin
      rmode = 1'($urandom_range(0, 1));
      rsrc  = 32'($urandom_range(0, 127)) * 32'd4 + 32'($urandom_range(0, 3));
      rdst  = 32'($urandom_range(0, 127)) * 32'd4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) rdst = 32'hFFFF_FFF0 + rdst[3:0];
      rlen  = 16'($urandom_range(0, 6));
      applyStimulus(rmode, rsrc, rdst, rlen, $urandom, -1, 1'($urandom_range(0, 1)), dn, fe, fv);
    end

    repeat (3) @(negedge clk);
    checkOutput("txn_queue_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("job_queue_drained", 32'(job_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
